// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store sequencer.
//   MEM_ACC_*   : access-size codes carried on req_acc_i (3 is illegal)
//   lsu_state_e : sequencer FSM states
package lsu_ctrl_pkg;

  localparam logic [1:0] MEM_ACC_B = 2'd0;
  localparam logic [1:0] MEM_ACC_H = 2'd1;
  localparam logic [1:0] MEM_ACC_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_DONE,
    ST_ERR
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane helper for the load/store sequencer.
//   acc, sext, addr_lo : access size, sign-extend flag, byte offset in word
//   wdata              : raw store data
//   rword              : raw memory read word
//   be                 : byte enables for the access
//   wdata_rep          : store data replicated across all lanes
//   rdata_ext          : load data shifted down and zero/sign-extended
//   misalign           : illegal size or unaligned address
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  acc,
  input  logic        sext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = rword >> {addr_lo, 3'b000};
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = shifted;
    misalign  = 1'b0;
    case (acc)
      MEM_ACC_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      MEM_ACC_H: begin
        be        = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sext & shifted[15]}}, shifted[15:0]};
        misalign  = addr_lo[0];
      end
      MEM_ACC_W: misalign = |addr_lo;
      default:   misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the decoder and the data-memory port.
//   clk_i, rstn_i          : clock, async active-low reset
//   req_*                  : access request from the decoder
//   stall_o                : hold PC while the access is in flight
//   done_o / err_o         : one-cycle completion / error pulses
//   rdata_o                : extended load data, valid with done_o
//   mem_* / mem_ready_i    : valid/ready data-memory transaction
// TIMEOUT_CYCLES bounds the BUS wait for mem_ready_i (0 disables it).
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_acc_i,
  input  logic        req_sext_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        mem_valid_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e  state;
  logic        we_q, sext_q;
  logic [1:0]  acc_q;
  logic [31:0] addr_q, wdata_q, rdata_q, wdog;
  logic [3:0]  be_q;
  logic        done_q, err_q, valid_q;

  logic [1:0]  a_acc, a_lo;
  logic        a_sext;
  logic [3:0]  be;
  logic [31:0] wdata_rep, rdata_ext;
  logic        misalign;
  logic        wdog_expire;

  // One aligner serves both phases: in IDLE it sees the incoming request
  // (alignment check, lane setup); afterwards it sees the latched request
  // so the read word is shifted/extended with the original offset/size.
  always_comb begin
    if (state == ST_IDLE) begin
      a_acc  = req_acc_i;
      a_sext = req_sext_i;
      a_lo   = req_addr_i[1:0];
    end else begin
      a_acc  = acc_q;
      a_sext = sext_q;
      a_lo   = addr_q[1:0];
    end
  end

  lsu_align u_align (
    .acc       (a_acc),
    .sext      (a_sext),
    .addr_lo   (a_lo),
    .wdata     (req_wdata_i),
    .rword     (mem_rdata_i),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext),
    .misalign  (misalign)
  );

  assign wdog_expire = (TIMEOUT_CYCLES != 0) && (wdog == TIMEOUT_CYCLES - 1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      acc_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      wdog    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            if (misalign) begin
              state <= ST_ERR;
              err_q <= 1'b1;
            end else begin
              state   <= ST_BUS;
              valid_q <= 1'b1;
              we_q    <= req_we_i;
              acc_q   <= req_acc_i;
              sext_q  <= req_sext_i;
              addr_q  <= req_addr_i;
              be_q    <= be;
              wdata_q <= wdata_rep;
            end
          end
        end
        ST_BUS: begin
          // valid_q is high throughout BUS, so ready alone completes it;
          // a handshake on the last allowed cycle wins over the watchdog.
          if (mem_ready_i) begin
            state   <= ST_DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            rdata_q <= rdata_ext;
            wdog    <= '0;
          end else if (wdog_expire) begin
            state   <= ST_ERR;
            valid_q <= 1'b0;
            err_q   <= 1'b1;
            wdog    <= '0;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          rdata_q <= '0;
        end
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Reset gates stall so it drops at once even while the decoder still
  // presents the interrupted request.
  assign stall_o     = rstn_i & ((state == ST_BUS) | ((state == ST_IDLE) & req_valid_i));
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_valid_o = valid_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = {addr_q[31:2], 2'b00};
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a per-cycle expectation derived from
// the access rules (byte-lane arithmetic, transaction timeline) is compared
// against the DUT on every falling edge; directed accesses add literal pins.
module tb_lsu_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        req_valid_i = 1'b0, req_we_i = 1'b0, req_sext_i = 1'b0;
  logic [1:0]  req_acc_i = '0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        stall_o, done_o, err_o, mem_valid_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;

  lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .req_valid_i (req_valid_i),
    .req_we_i    (req_we_i),
    .req_acc_i   (req_acc_i),
    .req_sext_i  (req_sext_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .mem_valid_o (mem_valid_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        exp_on = 1'b0;
  logic        exp_stall, exp_done, exp_err, exp_valid, exp_we, exp_rchk;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_be;
  logic        lit_on = 1'b0, lit_we;
  logic [3:0]  lit_be;
  logic [31:0] lit_wdata, lit_rdata;

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_be(int lo, int size);
    logic [3:0] b = '0;
    for (int i = 0; i < 4; i++)
      if (i >= lo && i < lo + size) b[i] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] m_wdata(logic [31:0] wd, int size);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % size) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] word, int lo, int size, logic sext);
    logic [31:0] v, mask;
    if (size == 4) return word;
    v    = word >> (8 * lo);
    mask = (32'd1 << (8 * size)) - 32'd1;
    v    = v & mask;
    if (sext && v[8*size-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- compare process ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_on) begin
      chk("stall_o", 32'(stall_o), 32'(exp_stall));
      chk("done_o", 32'(done_o), 32'(exp_done));
      chk("err_o", 32'(err_o), 32'(exp_err));
      chk("mem_valid_o", 32'(mem_valid_o), 32'(exp_valid));
      if (exp_valid) begin
        chk("mem_we_o", 32'(mem_we_o), 32'(exp_we));
        chk("mem_addr_o", mem_addr_o, exp_addr);
        chk("mem_be_o", 32'(mem_be_o), 32'(exp_be));
        chk("mem_wdata_o", mem_wdata_o, exp_wdata);
      end
      if (exp_rchk) chk("rdata_o", rdata_o, exp_rdata);
      if (lit_on && exp_valid) begin
        chk("lit_be", 32'(mem_be_o), 32'(lit_be));
        chk("lit_we", 32'(mem_we_o), 32'(lit_we));
        if (lit_we) chk("lit_wdata", mem_wdata_o, lit_wdata);
      end
      if (lit_on && exp_done) chk("lit_rdata", rdata_o, lit_rdata);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_quiet();
    exp_stall = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_valid = 1'b0;
    exp_we = 1'b0; exp_addr = '0; exp_be = '0; exp_wdata = '0;
    exp_rchk = 1'b1; exp_rdata = '0;
  endtask

  task automatic idle_cycle();
    req_valid_i = 1'b0;
    req_we_i    = 1'($urandom_range(0, 1));
    req_acc_i   = 2'($urandom_range(0, 3));
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    mem_ready_i = 1'($urandom_range(0, 1));
    mem_rdata_i = $urandom;
    set_quiet();
    tick();
  endtask

  // One full access: IDLE cycle, then ERR, or BUS cycles + DONE/ERR.
  // Ready rises in BUS cycle number 'waits' (0-based) unless the watchdog
  // (T cycles) expires first. The request stays presented to the end.
  task automatic run_txn(input logic we, input logic [1:0] acc, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wd, input int waits,
                         input logic [31:0] rword, input logic use_lit,
                         input logic [3:0] l_be, input logic [31:0] l_wd,
                         input logic [31:0] l_rd);
    int size, lo, nbus;
    logic bad;
    size = (acc == 2'd0) ? 1 : (acc == 2'd1) ? 2 : 4;
    lo   = int'(addr[1:0]);
    bad  = (acc == 2'd3) || (lo % size != 0);
    req_valid_i = 1'b1; req_we_i = we; req_acc_i = acc; req_sext_i = sext;
    req_addr_i = addr; req_wdata_i = wd;
    lit_be = l_be; lit_wdata = l_wd; lit_rdata = l_rd; lit_we = we;
    set_quiet();
    exp_stall   = 1'b1;
    mem_ready_i = 1'($urandom_range(0, 1));
    mem_rdata_i = $urandom;
    tick();
    if (bad) begin
      set_quiet();
      exp_err     = 1'b1;
      mem_ready_i = 1'($urandom_range(0, 1));
      tick();
    end else begin
      nbus = (waits < T) ? waits + 1 : T;
      for (int k = 0; k < nbus; k++) begin
        set_quiet();
        exp_stall = 1'b1; exp_valid = 1'b1; exp_we = we;
        exp_addr  = {addr[31:2], 2'b00};
        exp_be    = m_be(lo, size);
        exp_wdata = m_wdata(wd, size);
        lit_on    = use_lit;
        mem_ready_i = (k == waits);
        mem_rdata_i = (k == waits) ? rword : $urandom;
        tick();
      end
      set_quiet();
      lit_on      = 1'b0;
      mem_ready_i = 1'($urandom_range(0, 1));
      mem_rdata_i = $urandom;
      if (waits < T) begin
        exp_done = 1'b1;
        if (we) exp_rchk = 1'b0;
        else begin
          exp_rdata = m_load(rword, lo, size, sext);
          lit_on    = use_lit;
        end
      end else begin
        exp_err = 1'b1;
      end
      tick();
    end
    lit_on = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  acc;
    logic [31:0] addr;
    set_quiet();
    exp_on = 1'b1;
    tick();                 // reset state compared at the first falling edge
    rstn_i = 1'b1;
    idle_cycle();
    idle_cycle();

    // LW, zero wait
    run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b1, 4'hF, 32'h0, 32'hDEADBEEF);
    // LB sign / LBU from top byte
    run_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 32'h80FFFFFF, 1'b1, 4'b1000, 32'h0, 32'hFFFFFF80);
    run_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1, 32'h80FFFFFF, 1'b1, 4'b1000, 32'h0, 32'h00000080);
    idle_cycle();
    // SH with two wait cycles
    run_txn(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234ABCD, 2, 32'h0, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0);
    // misaligned word, illegal size
    run_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 32'h0, 1'b0, '0, '0, '0);
    run_txn(1'b1, 2'd3, 1'b0, 32'h400, 32'h55, 0, 32'h0, 1'b0, '0, '0, '0);
    // watchdog expiry, then last-cycle handshake just beating it
    run_txn(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 10, 32'h0, 1'b0, '0, '0, '0);
    run_txn(1'b0, 2'd1, 1'b1, 32'h402, 32'h0, T - 1, 32'h8001_7FFF, 1'b1, 4'b1100, 32'h0, 32'hFFFF8001);

    // reset asserted in the second BUS cycle
    req_valid_i = 1'b1; req_we_i = 1'b0; req_acc_i = 2'd2; req_sext_i = 1'b0;
    req_addr_i = 32'h500; req_wdata_i = 32'h0; mem_ready_i = 1'b0;
    set_quiet(); exp_stall = 1'b1;
    tick();
    set_quiet(); exp_stall = 1'b1; exp_valid = 1'b1; exp_addr = 32'h500; exp_be = 4'hF;
    tick();
    set_quiet();
    rstn_i = 1'b0;          // mid-cycle: outputs must fall before the next edge
    tick();
    set_quiet();
    req_valid_i = 1'b0;
    rstn_i = 1'b1;
    tick();
    run_txn(1'b0, 2'd2, 1'b0, 32'h600, 32'h0, 1, 32'hCAFEF00D, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D);

    for (int n = 0; n < 400; n++) begin
      acc  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (acc == 2'd1) addr[0] = 1'b0;
        else if (acc == 2'd2) addr[1:0] = 2'b00;
      end
      run_txn(1'($urandom_range(0, 1)), acc, 1'($urandom_range(0, 1)), addr, $urandom,
              int'($urandom_range(0, 5)), $urandom, 1'b0, '0, '0, '0);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    exp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer for the single-issue core. It sits between the instruction decoder and the data-memory port. For each load or store it receives an access request, checks alignment, and drives a valid/ready memory transaction with byte enables and lane-replicated write data. It stalls the PC until the access completes, then returns aligned, zero- or sign-extended load data for register write-back.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in BUS waiting for `mem_ready_i` before aborting with an error; 0 disables the watchdog.

Ports:
- clk_i  in  1  core clock; one clock domain, all state on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  decoder requests a memory access for the current instruction
- req_we_i  in  1  1 = store, 0 = load
- req_acc_i  in  2  access size: `MEM_ACC_B`=0, `MEM_ACC_H`=1, `MEM_ACC_W`=2; 3 is illegal
- req_sext_i  in  1  sign-extend load result (LB/LH); ignored for stores and words
- req_addr_i  in  32  byte address (rs1 + imm)
- req_wdata_i  in  32  store data (rs2)
- stall_o  out  1  hold PC; core selects `PC_NEXT_SEL_STALL`
- done_o  out  1  one-cycle pulse: access complete, `rdata_o` valid
- err_o  out  1  one-cycle pulse: misaligned, illegal size or bus timeout
- rdata_o  out  32  extended load data; valid only while `done_o`=1
- mem_valid_o  out  1  memory request valid
- mem_we_o  out  1  memory write
- mem_addr_o  out  32  word address, bits [1:0] = 0
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-replicated write data
- mem_ready_i  in  1  memory accepts/completes the transfer; qualifies `mem_rdata_i`
- mem_rdata_i  in  32  memory read word

## Operation
- FSM states: IDLE, BUS, DONE, ERR.
- IDLE:
  - `req_valid_i`=1 with a legal, aligned request: latch we/acc/sext/addr/wdata, then go to BUS.
  - Illegal or misaligned request: go to ERR, no bus activity.
  - `stall_o` = `req_valid_i` (combinational).
- Alignment rule: H needs addr[0]=0; W needs addr[1:0]=0; acc=3 is always an error.
- BUS:
  - `mem_valid_o`=1; we/addr/be/wdata come from latched registers and stay stable until the handshake.
  - On an edge with `mem_valid_o`&`mem_ready_i`: capture `mem_rdata_i`, go to DONE, clear the watchdog.
  - Otherwise the watchdog increments. If it reaches TIMEOUT_CYCLES (≠0), go to ERR with `mem_valid_o` dropped.
  - `stall_o`=1.
- DONE: `done_o`=1, `stall_o`=0, always go to IDLE. `req_valid_i` is ignored here because it still belongs to the retiring instruction.
- ERR: `err_o`=1, `stall_o`=0, no register write, always go to IDLE.
- Byte enables: B → 4'b0001<<addr[1:0]; H → 4'b0011<<addr[1:0]; W → 4'b1111.
- Write data: B → {4{wdata[7:0]}}; H → {2{wdata[15:0]}}; W → wdata.
- Load data: shift the captured word right by 8*addr[1:0], then:
  - B: extend from bit 7.
  - H: extend from bit 15.
  - W: pass through.
  - Extension is sign if sext=1, else zero.
- Decoder gates the load rd write with `done_o`.

## Timing
- Reset values: state=IDLE; `stall_o`, `done_o`, `err_o`, `mem_valid_o`, `mem_we_o` = 0; `mem_addr_o`, `mem_be_o`, `mem_wdata_o`, `rdata_o` = 0; watchdog = 0.
- Reset is asynchronous. Asserting it mid-BUS drops `mem_valid_o` immediately with no completion pulse.
- Zero-wait access: 3 cycles (IDLE-stall, BUS, DONE). Each wait cycle of `mem_ready_i` adds 1.
- Misaligned access: 2 cycles (IDLE-stall, ERR).
- `mem_ready_i` while `mem_valid_o`=0 is ignored.
- Back-to-back memory instructions: the next request is accepted in the IDLE cycle directly after DONE/ERR.
- `rdata_o` is registered and held 0 outside DONE.

## Structure
- Add `MEM_ACC_B/H/W` constants to const.v next to the existing ALU/PC select macros. Also add FSM state encodings there.
- Sub-module `lsu_align`: combinational; computes byte enables, write-lane replication, load shift/extend and the misalign flag.
- `lsu_ctrl` holds the FSM, the request latches, the read-data register and the watchdog counter.

## Test plan
- LW addr 0x100, memory returns 0xDEADBEEF with ready on first BUS cycle → `mem_be_o`=4'hF, `done_o` in cycle 3, `rdata_o`=0xDEADBEEF, `stall_o`=1 for cycles 1–2.
- LB sext=1, addr 0x103, rdata 0x80FF_FF_FF → `mem_be_o`=4'b1000, `rdata_o`=0xFFFFFF80. Same access with LBU → 0x00000080.
- SH addr 0x202, wdata 0x1234ABCD, ready after 2 wait cycles → `mem_we_o`=1, `mem_be_o`=4'b1100, `mem_wdata_o`=0xABCDABCD stable for all 3 BUS cycles; `done_o` in cycle 5.
- LW addr 0x101 → no `mem_valid_o`; `err_o` pulse in cycle 2; `done_o` stays 0.
- TIMEOUT_CYCLES=4, `mem_ready_i` held 0 → `mem_valid_o` high for 4 cycles, then `err_o` pulse, return to IDLE.
- `rstn_i` asserted in the 2nd BUS cycle → `mem_valid_o`/`stall_o` drop asynchronously. After release, a fresh LW completes normally.
